// File: rtl/expr_pipe_eval.sv
// Per-lane selectable expression evaluator: operands land in S1, results are queued in an output FIFO.
// One cycle from accept to FIFO write. in_ready is a credit (fifo_count + s1_valid < DEPTH), so S1 never stalls.

module expr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DCNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      cnt;
  logic             empty, full, wr_ok, rd_ok;

  assign empty = (cnt == '0);
  assign full  = (cnt == DCNT);
  assign rd_ok = rd_rdy && !empty;
  // A write into a full FIFO is allowed when the head leaves in the same cycle.
  assign wr_ok = wr_vld && (!full || rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_dat;
  end

  assign rd_vld = !empty;
  assign rd_dat = empty ? '0 : mem[rptr];
  assign count  = cnt;
endmodule

module expr_pipe_eval #(
  parameter int W     = 6,
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [LANES-1:0]     sgn,
  input  logic [LANES*W-1:0]   a,
  input  logic [LANES*W-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   y,
  output logic [LANES-1:0]     ovf
);
  localparam int CW = $clog2(DEPTH);
  localparam logic [CW+1:0] DLIM = DEPTH[CW+1:0];

  typedef struct packed {
    logic [LANES*W-1:0] y;
    logic [LANES-1:0]   ovf;
  } res_t;

  logic               s1_valid;
  logic [2:0]         s1_op;
  logic [LANES-1:0]   s1_sgn;
  logic [LANES*W-1:0] s1_a, s1_b;
  logic [CW:0]        fifo_count;
  logic [CW+1:0]      credits;
  logic               accept;
  logic [LANES*W-1:0] y_c;
  logic [LANES-1:0]   ovf_c;
  res_t               res_c, head;

  assign credits  = {1'b0, fifo_count} + {{(CW+1){1'b0}}, s1_valid};
  assign in_ready = (credits < DLIM);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_sgn   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= op;
        s1_sgn <= sgn;
        s1_a   <= a;
        s1_b   <= b;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W:0] ax, bx, r;
    logic       of;

    assign ax = {s1_sgn[i] & s1_a[i*W+W-1], s1_a[i*W +: W]};
    assign bx = {s1_sgn[i] & s1_b[i*W+W-1], s1_b[i*W +: W]};

    always_comb begin
      r  = '0;
      of = 1'b0;
      case (s1_op)
        3'd0: begin
          r  = ax + bx;
          of = s1_sgn[i] ? (r[W] ^ r[W-1]) : r[W];
        end
        3'd1: begin
          r  = ax - bx;
          of = s1_sgn[i] ? (r[W] ^ r[W-1]) : r[W];
        end
        3'd2: r = ax & bx;
        3'd3: r = ax ~^ bx;
        // Shifting the extended W+1-bit value gives sign fill or zero fill for free.
        3'd4: r = $signed(ax) >>> s1_b[i*W +: 3];
        3'd5: r = {{W{1'b0}}, ($signed(ax) < $signed(bx))};
        3'd6: r = {{W{1'b0}}, (ax == bx)};
        default: r = (ax != '0) ? bx : ~bx;
      endcase
    end

    assign y_c[i*W +: W] = r[W-1:0];
    assign ovf_c[i]      = of;
  end

  assign res_c = {y_c, ovf_c};

  expr_fifo #(.WIDTH($bits(res_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (s1_valid),
    .wr_dat (res_c),
    .rd_rdy (out_ready),
    .rd_vld (out_valid),
    .rd_dat (head),
    .count  (fifo_count)
  );

  assign y   = head.y;
  assign ovf = head.ovf;
endmodule

// File: doc/expr_pipe_eval.md
# expr_pipe_eval

Parametrised, pipelined successor to the vloghammer combinational expression blocks. It evaluates one selectable Verilog expression per lane across LANES independent operand pairs, with per-lane signedness. Results are registered into an output FIFO behind valid/ready handshakes. It sits in the regression suite as the sequential stimulus target for checking width, sign-extension and flow-control lowering.

## Interface
- W, default 6: operand and result width per lane (W ≥ 3).
- LANES, default 4: number of parallel lanes.
- DEPTH, default 4: output FIFO depth (power of two, ≥ 2).

- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operand beat is offered.
- in_ready  out  1  the block accepts a beat this cycle.
- op  in  3  opcode, applies to all lanes of the beat.
- sgn  in  LANES  per-lane signed (1) or unsigned (0) interpretation.
- a, b  in  LANES*W  operands; lane i occupies [i*W +: W], lane 0 at the LSBs.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head.
- y  out  LANES*W  result, packed like a.
- ovf  out  LANES  per-lane overflow flag of the head entry.

## Operation
- Accept on in_valid && in_ready. a, b, sgn and op are captured into stage register S1, and s1_valid is set.
- The next cycle computes all lanes combinationally from S1 and writes {y, ovf} into the FIFO. s1_valid then clears unless a new beat was accepted in the same cycle.
- in_ready = (fifo_count + s1_valid) < DEPTH. This is credit-based, so S1 never stalls and never overwrites.
- Opcodes, with per-lane operands extended to W+1 bits (sign-extended if sgn[i], else zero-extended):
  - 0: a + b.
  - 1: a − b.
  - 2: a & b.
  - 3: a ^~ b.
  - 4: a >>> b[2:0]. Arithmetic if signed, logical if unsigned. A shift amount ≥ W gives all sign bits or zero.
  - 5: a < b. The 1-bit result is zero-extended.
  - 6: a == b. The 1-bit result is zero-extended.
  - 7: (a != 0) ? b : ~b.
- Each result is truncated to W bits.
- ovf[i] applies to ops 0/1 only:
  - Signed lanes: set when the W+1-bit result's top two bits differ.
  - Unsigned lanes: set on carry-out (op 0) or borrow (op 1).
  - Other ops: ovf[i] = 0.
- FIFO write and read may both happen in the same cycle, including when full. fifo_count is then unchanged.
- Read pointer and write pointer wrap modulo DEPTH.
- y and ovf always present the FIFO head. They hold their value while out_valid && !out_ready.
- When the FIFO is empty, y and ovf are 0.

## Timing
- Reset, asynchronous and immediate, sets all of the following:
  - s1_valid = 0.
  - fifo_count = 0 and both pointers = 0.
  - out_valid = 0, y = 0, ovf = 0.
  - in_ready = 1, valid as soon as rst_n is high.
- Latency: a beat accepted at edge k is written at edge k+1. out_valid is high after edge k+1 when the FIFO was empty.
- Throughput: 1 beat/cycle while out_ready is held high.
- Full: with fifo_count + s1_valid = DEPTH, in_ready = 0. in_ready returns in the cycle after the first pop.
- Reset mid-operation discards S1 and all FIFO contents. No partial output is ever presented.
- in_valid high with in_ready low is legal. The beat is not taken, and the source holds it.

## Test plan
- Reset: assert rst_n=0 with in_valid=1 mid-stream -> immediately out_valid=0, y=0, ovf=0; after release, in_ready=1.
- Add (W=6, op=0):
  - lane0 sgn=1, a=31, b=1 -> y0=6'b100000, ovf0=1.
  - lane1 sgn=0, a=63, b=1 -> y1=0, ovf1=1.
  - lane2 sgn=1, a=−3, b=2 -> y2=6'b111111, ovf2=0.
  - out_valid high exactly one edge after acceptance.
- Shift/compare, a=6'b100000, b=2:
  - op=4, signed -> 6'b111000; unsigned -> 6'b001000.
  - op=5, a=6'b111111, b=1: signed -> 1; unsigned -> 0.
- Backpressure (DEPTH=4), out_ready=0, in_valid=1 every cycle:
  - exactly 4 beats accepted, then in_ready=0.
  - raise out_ready -> results emerge in order with tags 0..3.
  - in_ready=1 the cycle after the first pop.
- Simultaneous push/pop with FIFO full and out_ready=1, 20 back-to-back beats -> no beat lost or duplicated; pointers wrap; order preserved.
- Op 7, a=0, b=6'b000101 -> 6'b111010; a=1 -> 6'b000101; ovf=0 for all lanes.
